// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line timing, frame length.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned DefaultClkFreq  = 50_000_000;
  localparam int unsigned DefaultBaudRate = 115_200;
  localparam int unsigned FrameBits       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
`timescale 1ns/1ps
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  // Shift the raw line through two flops before anything looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM with a bit-period counter and shift register.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DefaultClkFreq,
  parameter int unsigned BAUD_RATE    = DefaultBaudRate,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [FrameBits-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(FrameBits);

  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  // Half a bit period after the start edge lands in the middle of the start bit.
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FrameBits - 1);

  logic                 w_rx_s;
  uart_state_e          r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [IdxW-1:0]      r_bit_idx, w_bit_idx_next;
  logic [FrameBits-1:0] r_shift, w_shift_next;
  logic [FrameBits-1:0] r_data, w_data_next;
  logic                 r_valid, w_valid_next;
  logic                 r_frame_err, w_frame_err_next;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  // State, counter, shift register and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Next-state logic: each sample point is where the counter reaches its terminal value.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_frame_err_next = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_cnt_next     = '0;
        w_bit_idx_next = '0;
        if (!w_rx_s) begin
          w_state_next = StStart;
        end
      end

      StStart: begin
        if (r_cnt == CntHalf) begin
          w_cnt_next = '0;
          // Line back high at mid start bit: treat as a glitch, no pulse.
          w_state_next = w_rx_s ? StIdle : StData;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      StData: begin
        if (r_cnt == CntFull) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rx_s, r_shift[FrameBits-1:1]};
          if (r_bit_idx == IdxLast) begin
            w_bit_idx_next = '0;
            w_state_next   = StStop;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      StStop: begin
        if (r_cnt == CntFull) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = StWaitIdle;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      StWaitIdle: begin
        // A held-low line (break) must not look like a new start bit.
        w_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver; DUT clocked at 10 MHz so a 115200 bit period is 86 clocks.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam real BitNs   = 8681.0;
  localparam int  HalfBit = 43;  // CLKS_PER_BIT/2 for 10 MHz / 115200

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int n_valid     = 0;
  int n_ferr      = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic [7:0] rx_bytes[$];

  logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

  always #50 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ (10_000_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Pulse monitor: records received bytes and checks pulse width / exclusivity at all times.
  always @(negedge clk) begin
    if (valid) begin
      n_valid = n_valid + 1;
      rx_bytes.push_back(data);
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (valid || frame_err) begin
      vectors = vectors + 1;
      if ((valid && frame_err) || (valid && prev_valid) || (frame_err && prev_ferr)) begin
        $display("FAIL pulse_shape: valid=%b frame_err=%b prev_valid=%b prev_ferr=%b, need single exclusive pulses",
                 valid, frame_err, prev_valid, prev_ferr);
        miscompares = miscompares + 1;
      end
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (100) @(negedge clk);
    vectors += 4;
    if (data !== 8'h00) begin $display("FAIL reset_data: got %h want 00", data); miscompares++; end
    if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", valid); miscompares++; end
    if (frame_err !== 1'b0) begin $display("FAIL reset_ferr: got %b want 0", frame_err); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int v0 = n_valid;
    int f0 = n_ferr;
    send_frame(8'h48, 1'b1, BitNs);
    @(negedge clk);
    vectors += 3;
    if (n_valid - v0 !== 1) begin $display("FAIL single_count: got %0d want 1", n_valid - v0); miscompares++; end
    if (data !== 8'h48) begin $display("FAIL single_data: got %h want 48", data); miscompares++; end
    if (n_ferr - f0 !== 0) begin $display("FAIL single_ferr: got %0d want 0", n_ferr - f0); miscompares++; end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    rx_bytes.delete();
    for (int i = 0; i < 13; i++) send_frame(hello[i], 1'b1, BitNs);
    @(negedge clk);
    vectors++;
    if (n_valid - v0 !== 13) begin $display("FAIL b2b_count: got %0d want 13", n_valid - v0); miscompares++; end
    for (int i = 0; i < 13; i++) begin
      vectors++;
      if (i >= rx_bytes.size()) begin
        $display("FAIL b2b_byte%0d: got none want %h", i, hello[i]); miscompares++;
      end else if (rx_bytes[i] !== hello[i]) begin
        $display("FAIL b2b_byte%0d: got %h want %h", i, rx_bytes[i], hello[i]); miscompares++;
      end
    end
  endtask

  task automatic test_glitch();
    int v0 = n_valid;
    int f0 = n_ferr;
    int n  = 0;
    bit seen_busy = 0;
    repeat (4) @(negedge clk);
    rx = 1'b0;
    // 2 us low, then busy must drop by half a bit plus synchronizer/register latency.
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 20) rx = 1'b1;
      if (busy) seen_busy = 1;
      n = i;
      if (seen_busy && !busy) break;
    end
    rx = 1'b1;
    vectors += 4;
    if (!seen_busy) begin $display("FAIL glitch_busy_rise: got 0 want 1"); miscompares++; end
    if (busy !== 1'b0 || n > HalfBit + 4) begin
      $display("FAIL glitch_busy_fall: busy=%b after %0d clks, want 0 within %0d", busy, n, HalfBit + 4);
      miscompares++;
    end
    repeat (100) @(negedge clk);
    if (n_valid - v0 !== 0) begin $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); miscompares++; end
    if (n_ferr - f0 !== 0) begin $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); miscompares++; end
  endtask

  task automatic test_frame_err();
    int v0 = n_valid;
    int f0 = n_ferr;
    send_frame(8'hA5, 1'b0, BitNs);
    #(20.0 * BitNs);
    @(negedge clk);
    vectors += 4;
    if (n_ferr - f0 !== 1) begin $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); miscompares++; end
    if (n_valid - v0 !== 0) begin $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); miscompares++; end
    if (data !== 8'h21) begin $display("FAIL ferr_data_hold: got %h want 21", data); miscompares++; end
    if (busy !== 1'b1) begin $display("FAIL ferr_busy_break: got %b want 1", busy); miscompares++; end
    rx = 1'b1;
    #(BitNs);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin $display("FAIL ferr_busy_release: got %b want 0", busy); miscompares++; end
    send_frame(8'h3C, 1'b1, BitNs);
    @(negedge clk);
    vectors += 2;
    if (n_valid - v0 !== 1) begin $display("FAIL ferr_next_count: got %0d want 1", n_valid - v0); miscompares++; end
    if (data !== 8'h3C) begin $display("FAIL ferr_next_data: got %h want 3C", data); miscompares++; end
  endtask

  task automatic test_reset_abort();
    int v0 = n_valid;
    int f0 = n_ferr;
    rx = 1'b0;
    #(BitNs);
    rx = 1'b1;
    #(4.5 * BitNs);  // middle of data bit 4 of 8'hFF
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    vectors += 2;
    if (busy !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", busy); miscompares++; end
    if (data !== 8'h00) begin $display("FAIL abort_data_rst: got %h want 00", data); miscompares++; end
    rst = 1'b0;
    #(6.0 * BitNs);
    @(negedge clk);
    vectors += 3;
    if (n_valid - v0 !== 0) begin $display("FAIL abort_valid: got %0d want 0", n_valid - v0); miscompares++; end
    if (n_ferr - f0 !== 0) begin $display("FAIL abort_ferr: got %0d want 0", n_ferr - f0); miscompares++; end
    if (data !== 8'h00) begin $display("FAIL abort_data: got %h want 00", data); miscompares++; end
    send_frame(8'h0F, 1'b1, BitNs);
    @(negedge clk);
    vectors += 2;
    if (n_valid - v0 !== 1) begin $display("FAIL abort_next_count: got %0d want 1", n_valid - v0); miscompares++; end
    if (data !== 8'h0F) begin $display("FAIL abort_next_data: got %h want 0F", data); miscompares++; end
  endtask

  task automatic test_skew();
    int v0 = n_valid;
    send_frame(8'h55, 1'b1, BitNs * 1.03);
    @(negedge clk);
    vectors += 2;
    if (n_valid - v0 !== 1) begin $display("FAIL skew_slow_count: got %0d want 1", n_valid - v0); miscompares++; end
    if (data !== 8'h55) begin $display("FAIL skew_slow_data: got %h want 55", data); miscompares++; end
    send_frame(8'hAA, 1'b1, BitNs);  // different byte in between so the next check is meaningful
    send_frame(8'h55, 1'b1, BitNs * 0.97);
    @(negedge clk);
    vectors += 2;
    if (n_valid - v0 !== 3) begin $display("FAIL skew_fast_count: got %0d want 3", n_valid - v0); miscompares++; end
    if (data !== 8'h55) begin $display("FAIL skew_fast_data: got %h want 55", data); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
    test_skew();
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001: The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002: The block SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate in bits/s.
REQ-003: The block SHALL have parameter CLKS_PER_BIT, default CLK_FREQ/BAUD_RATE (434), meaning clocks per bit period.
REQ-004: The block SHALL have port clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005: The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006: The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007: The block SHALL have port data  output  8  last correctly received byte.
REQ-008: The block SHALL have port valid  output  1  one-clock pulse when data updates.
REQ-009: The block SHALL have port frame_err  output  1  one-clock pulse on bad stop bit.
REQ-010: The block SHALL have port busy  output  1  high while a frame is in progress (state other than IDLE).

Function
REQ-011: The block SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012: The block SHALL receive frame format 8N1: start bit low, 8 data bits LSB first, one stop bit high, no parity.
REQ-013: The block SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014: IDLE: on rx_s = 0, the block SHALL go to START and clear the bit-period counter.
REQ-015: START: at count CLKS_PER_BIT/2-1 (216), the block SHALL go to DATA if rx_s = 0, else return to IDLE as a glitch, with no pulse.
REQ-016: DATA: the block SHALL sample rx_s every CLKS_PER_BIT clocks (mid-bit) into a shift register, bit index 0..7; after bit 7 it SHALL go to STOP.
REQ-017: STOP: at mid stop bit, if rx_s = 1 the block SHALL load data, pulse valid for exactly one clock, and go to IDLE.
REQ-018: STOP: at mid stop bit, if rx_s = 0 the block SHALL pulse frame_err for one clock, leave data unchanged, and go to WAIT_IDLE.
REQ-019: WAIT_IDLE: the block SHALL remain until rx_s = 1, then go to IDLE; it SHALL not restart on a held-low line (break).
REQ-020: Latency: valid SHALL assert on the clock after the stop-bit mid-sample, about 9.5 bit periods after the start falling edge, plus 2 synchronizer clocks.
REQ-021: The counter SHALL be wide enough for CLKS_PER_BIT-1 ($clog2), wrap to 0 at each bit boundary, and never overflow.
REQ-022: Back-to-back frames: a start edge arriving right after valid (line low in IDLE) SHALL be accepted with no gap clocks required.
REQ-023: valid and frame_err SHALL never be high in the same clock.
REQ-024: data SHALL hold its value between valid pulses; there is no downstream handshake, and an unread byte is overwritten.

Reset
REQ-025: While rst = 1, state SHALL be IDLE, counter and bit index 0, data = 8'h00, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1.
REQ-026: rst asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after release, reception resumes at the next falling edge.

Structure
REQ-027: The package uart_pkg SHALL hold the state enumeration, the default CLK_FREQ and BAUD_RATE, and the frame length constant (8 data bits), shared with the transmitter.
REQ-028: The block SHALL instantiate one sub-module, uart_sync2 (2-flop synchronizer, reset value 1); the FSM, counter and shift register are inline.

Verification
REQ-029: Reset for 100 clocks, then drive 8'h48 at 115200 (8681 ns/bit) -> a single valid pulse, data = 8'h48, frame_err = 0.
REQ-030: Send "Hello, World!" (0x48 0x65 0x6C 0x6C 0x6F 0x2C 0x20 0x57 0x6F 0x72 0x6C 0x64 0x21) back-to-back with no idle gap -> 13 valid pulses in order, matching bytes.
REQ-031: Low glitch of 2 us on an idle line -> no valid, no frame_err, busy returns to 0 within 217 clocks of the falling edge.
REQ-032: Send 8'hA5 with the stop bit forced low, then hold the line low for 20 bit periods -> frame_err pulses once, data keeps its previous value, busy stays high until rx returns high, then the next 8'h3C is received correctly.
REQ-033: Assert rst during data bit 4 of 8'hFF -> no pulse, data = 8'h00; the following frame 8'h0F -> valid with data = 8'h0F.
REQ-034: Bench checks at all times: valid and frame_err are each at most one clock wide and never high together; also send 8'h55 with the bit period skewed ±3% -> still received correctly.
